shift_ex_stage: RTL and testbench

- EX pipeline stage for MIPS shift instructions (SLL, SRL, SRA, SLLV, SRLV, SRAV).
- Accepts decoded shift ops from ID over a valid/allowin handshake and registers them in the ID/EX latch.
- Derives shift amount and type, drives the existing combinational shifter `shift`, and presents the result to MEM over the same handshake style.
- Also drives the EX forwarding/bypass port back to ID.

---
 rtl/cpu_defs.sv | 21 ++
 rtl/shift.sv | 24 ++
 rtl/shift_ex_stage.sv | 112 +++++++++++
 tb/tb_shift_ex_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: shift op one-hot bit positions, shifter type encodings and datapath widths.
package cpu_defs;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned GPR_W   = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned SH_W    = 3;

  localparam int unsigned OP_SLL  = 0;
  localparam int unsigned OP_SRL  = 1;
  localparam int unsigned OP_SRA  = 2;
  localparam int unsigned OP_SLLV = 3;
  localparam int unsigned OP_SRLV = 4;
  localparam int unsigned OP_SRAV = 5;

  localparam logic [SH_W-1:0] SH_LEFT  = 3'b001;
  localparam logic [SH_W-1:0] SH_LOGIC = 3'b010;
  localparam logic [SH_W-1:0] SH_ARITH = 3'b100;

endpackage

// File: rtl/shift.sv
// Combinational barrel shifter; result is the OR of every shift kind selected in sh_type.
module shift
  import cpu_defs::*;
(
  input  logic [XLEN-1:0]    x,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [SH_W-1:0]    sh_type,
  output logic [XLEN-1:0]    y
);

  logic [XLEN-1:0] sll_c;
  logic [XLEN-1:0] srl_c;
  logic [XLEN-1:0] sra_c;

  always_comb begin
    sll_c = x << shamt;
    srl_c = x >> shamt;
    sra_c = XLEN'($signed(x) >>> shamt);
    y     = ({XLEN{sh_type[0]}} & sll_c)
          | ({XLEN{sh_type[1]}} & srl_c)
          | ({XLEN{sh_type[2]}} & sra_c);
  end

endmodule

// File: rtl/shift_ex_stage.sv
// EX stage for MIPS shift ops: ID/EX latch with valid/allowin handshake, amount/type decode,
// shifter instance and the EX forwarding port.
module shift_ex_stage
  import cpu_defs::*;
#(
  parameter logic FWD_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ds_to_es_valid,
  output logic                 es_allowin,
  input  logic [OP_W-1:0]      ds_op,
  input  logic [SHAMT_W-1:0]   ds_sa,
  input  logic [XLEN-1:0]      ds_rs_val,
  input  logic [XLEN-1:0]      ds_rt_val,
  input  logic [GPR_W-1:0]     ds_dest,
  input  logic [XLEN-1:0]      ds_pc,
  input  logic                 es_flush,
  input  logic                 ms_allowin,
  output logic                 es_to_ms_valid,
  output logic [XLEN-1:0]      es_result,
  output logic [GPR_W-1:0]     es_dest,
  output logic [XLEN-1:0]      es_pc,
  output logic                 es_fwd_valid,
  output logic [GPR_W-1:0]     es_fwd_dest,
  output logic [XLEN-1:0]      es_fwd_data
);

  logic                es_valid_q;
  logic [OP_W-1:0]     op_q;
  logic [SHAMT_W-1:0]  sa_q;
  logic [XLEN-1:0]     rs_q;
  logic [XLEN-1:0]     rt_q;
  logic [GPR_W-1:0]    dest_q;
  logic [XLEN-1:0]     pc_q;

  logic                es_ready_go;
  logic                load_c;
  logic [SHAMT_W-1:0]  shamt_c;
  logic [SH_W-1:0]     sh_type_c;
  logic [XLEN-1:0]     sh_y;
  logic                unused_rs_hi;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign load_c         = ds_to_es_valid && es_allowin && !es_flush;
  assign unused_rs_hi   = ^rs_q[XLEN-1:SHAMT_W];

  // Flush outranks acceptance; payload only moves on a real capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      op_q       <= '0;
      sa_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      pc_q       <= '0;
    end else begin
      if (es_flush) begin
        es_valid_q <= 1'b0;
      end else if (es_allowin) begin
        es_valid_q <= ds_to_es_valid;
      end
      if (load_c) begin
        op_q   <= ds_op;
        sa_q   <= ds_sa;
        rs_q   <= ds_rs_val;
        rt_q   <= ds_rt_val;
        dest_q <= ds_dest;
        pc_q   <= ds_pc;
      end
    end
  end

  // Variable forms take the amount from rs[4:0]; type is a one-hot shifter select.
  always_comb begin
    shamt_c   = sa_q;
    sh_type_c = '0;
    if (op_q[OP_SLLV] || op_q[OP_SRLV] || op_q[OP_SRAV]) begin
      shamt_c = rs_q[SHAMT_W-1:0];
    end
    if (op_q[OP_SLL] || op_q[OP_SLLV]) sh_type_c = sh_type_c | SH_LEFT;
    if (op_q[OP_SRL] || op_q[OP_SRLV]) sh_type_c = sh_type_c | SH_LOGIC;
    if (op_q[OP_SRA] || op_q[OP_SRAV]) sh_type_c = sh_type_c | SH_ARITH;
  end

  shift u_shift (
    .x       (rt_q),
    .shamt   (shamt_c),
    .sh_type (sh_type_c),
    .y       (sh_y)
  );

  assign es_result = sh_y;
  assign es_dest   = dest_q;
  assign es_pc     = pc_q;

  generate
    if (FWD_EN) begin : g_fwd
      assign es_fwd_valid = es_valid_q && (dest_q != '0);
      assign es_fwd_dest  = dest_q;
      assign es_fwd_data  = sh_y;
    end else begin : g_no_fwd
      assign es_fwd_valid = 1'b0;
      assign es_fwd_dest  = '0;
      assign es_fwd_data  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_shift_ex_stage.sv
// Bench for shift_ex_stage: directed cases plus random traffic against a behavioural stage model.
module tb_shift_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_to_es_valid;
  logic [5:0]  ds_op;
  logic [4:0]  ds_sa;
  logic [31:0] ds_rs_val;
  logic [31:0] ds_rt_val;
  logic [4:0]  ds_dest;
  logic [31:0] ds_pc;
  logic        es_flush;
  logic        ms_allowin;

  logic        es_allowin, es_to_ms_valid, es_fwd_valid;
  logic [31:0] es_result, es_pc, es_fwd_data;
  logic [4:0]  es_dest, es_fwd_dest;
  logic        n_allowin, n_to_ms_valid, n_fwd_valid;
  logic [31:0] n_result, n_pc, n_fwd_data;
  logic [4:0]  n_dest, n_fwd_dest;

  always #5 clk = ~clk;

  shift_ex_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_op(ds_op), .ds_sa(ds_sa), .ds_rs_val(ds_rs_val), .ds_rt_val(ds_rt_val),
    .ds_dest(ds_dest), .ds_pc(ds_pc), .es_flush(es_flush), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_result(es_result), .es_dest(es_dest), .es_pc(es_pc),
    .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest), .es_fwd_data(es_fwd_data)
  );

  shift_ex_stage #(.FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .es_allowin(n_allowin),
    .ds_op(ds_op), .ds_sa(ds_sa), .ds_rs_val(ds_rs_val), .ds_rt_val(ds_rt_val),
    .ds_dest(ds_dest), .ds_pc(ds_pc), .es_flush(es_flush), .ms_allowin(ms_allowin),
    .es_to_ms_valid(n_to_ms_valid), .es_result(n_result), .es_dest(n_dest), .es_pc(n_pc),
    .es_fwd_valid(n_fwd_valid), .es_fwd_dest(n_fwd_dest), .es_fwd_data(n_fwd_data)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model of the held entry
  logic        m_valid;
  logic [5:0]  m_op;
  logic [4:0]  m_sa;
  logic [31:0] m_rs, m_rt, m_pc;
  logic [4:0]  m_dest;

  // Samples from the last checked cycle, for directed literal checks
  logic        s_valid, s_allowin, s_fwd_valid;
  logic [31:0] s_result, s_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Spec-level shift: left = multiply by 2^n, logical right = divide, arithmetic = sign-extended divide.
  function automatic logic [31:0] ref_shift(input logic [5:0] op, input logic [4:0] sa,
                                            input logic [31:0] rs, input logic [31:0] rt);
    longint unsigned amt, p, r, ext;
    amt = (op[5:3] != 3'b000) ? longint'(rs[4:0]) : longint'(sa);
    p   = 64'd1 << amt;
    r   = 0;
    ext = rt[31] ? (64'hFFFF_FFFF_0000_0000 | longint'(rt)) : longint'(rt);
    if (op[0] || op[3]) r = r | ((longint'(rt) * p) & 64'hFFFF_FFFF);
    if (op[1] || op[4]) r = r | (longint'(rt) / p);
    if (op[2] || op[5]) r = r | ((ext >> amt) & 64'hFFFF_FFFF);
    return 32'(r);
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] sa,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] dest,
                       input logic [31:0] pc, input logic msal, input logic fl);
    ds_to_es_valid = v;  ds_op = op;  ds_sa = sa;  ds_rs_val = rs;  ds_rt_val = rt;
    ds_dest = dest;  ds_pc = pc;  ms_allowin = msal;  es_flush = fl;
  endtask

  task automatic idle(input logic msal);
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0, msal, 1'b0);
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic tick();
    logic [31:0] exp_res;
    logic        exp_allow;
    #4;
    exp_res   = ref_shift(m_op, m_sa, m_rs, m_rt);
    exp_allow = !m_valid || ms_allowin;
    check("to_ms_valid", 32'(es_to_ms_valid), 32'(m_valid));
    check("allowin", 32'(es_allowin), 32'(exp_allow));
    check("result", es_result, exp_res);
    check("dest", 32'(es_dest), 32'(m_dest));
    check("pc", es_pc, m_pc);
    check("fwd_valid", 32'(es_fwd_valid), 32'(m_valid && (m_dest != 5'd0)));
    check("fwd_dest", 32'(es_fwd_dest), 32'(m_dest));
    check("fwd_data", es_fwd_data, exp_res);
    check("nofwd_zero", {n_fwd_data[31:6], n_fwd_valid, n_fwd_dest} | 32'(n_fwd_data[5:0]), 32'd0);
    s_valid = es_to_ms_valid;  s_allowin = es_allowin;  s_fwd_valid = es_fwd_valid;
    s_result = es_result;  s_pc = es_pc;
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;  m_op = '0;  m_sa = '0;  m_rs = '0;  m_rt = '0;  m_dest = '0;  m_pc = '0;
    end else begin
      if (ds_to_es_valid && exp_allow && !es_flush) begin
        m_op = ds_op;  m_sa = ds_sa;  m_rs = ds_rs_val;  m_rt = ds_rt_val;
        m_dest = ds_dest;  m_pc = ds_pc;
      end
      if (es_flush) m_valid = 1'b0;
      else if (exp_allow) m_valid = ds_to_es_valid;
    end
    #1;
  endtask

  initial begin
    logic [5:0] rop;
    int unsigned k;
    m_valid = 1'b0;  m_op = '0;  m_sa = '0;  m_rs = '0;  m_rt = '0;  m_dest = '0;  m_pc = '0;
    reset = 1'b1;
    idle(1'b1);
    @(posedge clk); #1;
    tick();
    reset = 1'b0;
    // Reset state
    idle(1'b0);
    tick();
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_allowin", 32'(s_allowin), 32'd1);
    check("rst_result", s_result, 32'd0);

    // SLL sa=4
    drive(1'b1, 6'b000001, 5'd4, 32'd0, 32'h0000_00F1, 5'd3, 32'h1000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 6'b100000, 5'd0, 32'h24, 32'h8000_0000, 5'd4, 32'h1004, 1'b1, 1'b0);
    tick();
    check("sll_valid", 32'(s_valid), 32'd1);
    check("sll_result", s_result, 32'h0000_0F10);
    drive(1'b1, 6'b010000, 5'd0, 32'h24, 32'h8000_0000, 5'd4, 32'h1008, 1'b1, 1'b0);
    tick();
    check("srav_result", s_result, 32'hF800_0000);
    idle(1'b1);
    tick();
    check("srlv_result", s_result, 32'h0800_0000);

    // Backpressure with SRL sa=31
    drive(1'b1, 6'b000010, 5'd31, 32'd0, 32'hFFFF_FFFF, 5'd7, 32'h2000, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b000001, 5'd1, 32'd0, 32'h3, 5'd8, 32'h2004, 1'b0, 1'b0);
      tick();
      check("bp_result", s_result, 32'h0000_0001);
      check("bp_allowin", 32'(s_allowin), 32'd0);
      check("bp_pc", s_pc, 32'h2000);
    end
    drive(1'b1, 6'b000001, 5'd1, 32'd0, 32'h3, 5'd8, 32'h2004, 1'b1, 1'b0);
    tick();
    check("bp_release_allowin", 32'(s_allowin), 32'd1);
    idle(1'b1);
    tick();
    check("bp_new_pc", s_pc, 32'h2004);
    check("bp_new_result", s_result, 32'h6);

    // Back-to-back streaming
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 6'b000001, 5'(i), 32'd0, 32'h1, 5'(i + 1), 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      else idle(1'b1);
      tick();
      if (i >= 1 && i <= 4) begin
        check("stream_valid", 32'(s_valid), 32'd1);
        check("stream_pc", s_pc, 32'h100 + 32'(4 * (i - 1)));
      end
    end

    // Flush during a stall with a new arrival
    drive(1'b1, 6'b000100, 5'd2, 32'd0, 32'h8000_0010, 5'd9, 32'h3000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 6'b000001, 5'd0, 32'd0, 32'h5, 5'd10, 32'h3004, 1'b0, 1'b1);
    tick();
    check("flush_allowin", 32'(s_allowin), 32'd0);
    idle(1'b0);
    tick();
    check("flush_valid", 32'(s_valid), 32'd0);
    check("flush_no_capture", s_pc, 32'h3000);

    // Reset during a stall
    drive(1'b1, 6'b000001, 5'd3, 32'd0, 32'h11, 5'd11, 32'h4000, 1'b1, 1'b0);
    tick();
    idle(1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_stall_valid", 32'(s_valid), 32'd0);
    check("rst_stall_result", s_result, 32'd0);

    // Forwarding
    drive(1'b1, 6'b000001, 5'd1, 32'd0, 32'h7, 5'd0, 32'h5000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 6'b000001, 5'd1, 32'd0, 32'h7, 5'd5, 32'h5004, 1'b1, 1'b0);
    tick();
    check("fwd_dest0_valid", 32'(s_fwd_valid), 32'd0);
    idle(1'b1);
    tick();
    check("fwd_dest5_valid", 32'(s_fwd_valid), 32'd1);
    check("fwd_dest5_data", s_result, 32'hE);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 6);
      rop = (k == 6) ? 6'd0 : 6'(1 << k);
      drive(1'($urandom_range(0, 3) != 0), rop, 5'($urandom), $urandom, $urandom,
            5'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
